// File: rtl/level_display.sv
// level_display
// Debounced thermometer-coded liquid-level indicator driving a 7-segment
// display plus status flags. A non-thermometer sensor code is treated as a
// sensor fault and shown as a blinking 'E'.
//
// Ports:
//   clk_2   in   1            clock, all state updates on rising edge
//   rst_n   in   1            asynchronous active-low reset
//   sensor  in   NSENS        bit i = liquid at sensor i, bit 0 lowest
//   SEG     out  8            bit 7 = decimal point, bits 6:0 = gfedcba
//   level   out  LW           accepted level 0..NSENS
//   valid   out  1            accepted code is a legal thermometer code
//   fault   out  1            = !valid
//   empty   out  1            valid && level == 0
//   full    out  1            valid && level == NSENS
module level_display #(
  parameter  int NSENS      = 3,
  parameter  int DEB_CYCLES = 4,
  parameter  int BLINK_HALF = 2,
  localparam int LW         = $clog2(NSENS + 1)
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic [NSENS-1:0] sensor,
  output logic [7:0]       SEG,
  output logic [LW-1:0]    level,
  output logic             valid,
  output logic             fault,
  output logic             empty,
  output logic             full
);

  // Counter widths are kept at least one bit wide so DEB_CYCLES=1 and
  // BLINK_HALF=1 still elaborate.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

  logic [NSENS-1:0] r_cand;
  logic [CW-1:0]    r_cnt;
  logic [NSENS-1:0] r_stable;
  logic [BW-1:0]    r_blink_cnt;
  logic             r_phase;

  logic             w_valid;
  logic [LW-1:0]    w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_fault;
  logic [3:0]       w_digit;
  logic [7:0]       w_seg;

  // A thermometer code 2^k-1 becomes a power of two when incremented, so it
  // shares no set bit with its successor.
  function automatic logic is_thermo(input logic [NSENS-1:0] s);
    logic [NSENS:0] w_ext;
    logic [NSENS:0] w_inc;
    w_ext = {1'b0, s};
    w_inc = w_ext + {{NSENS{1'b0}}, 1'b1};
    return (w_ext & w_inc) == {(NSENS + 1){1'b0}};
  endfunction

  function automatic logic [LW-1:0] popcount(input logic [NSENS-1:0] s);
    logic [LW-1:0] c;
    c = {LW{1'b0}};
    for (int i = 0; i < NSENS; i++) begin
      c = c + LW'(s[i]);
    end
    return c;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Debouncer: a candidate must be seen DEB_CYCLES consecutive edges before
  // it is committed to r_stable; any change restarts the count.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_cand   <= {NSENS{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_stable <= {NSENS{1'b0}};
    end else if (sensor != r_cand) begin
      r_cand <= sensor;
      r_cnt  <= {CW{1'b0}};
    end else if (r_cnt == CNT_MAX) begin
      r_stable <= r_cand;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Code validation and derived flags.
  always_comb begin
    w_valid = is_thermo(r_stable);
    w_level = {LW{1'b0}};
    if (w_valid) begin
      w_level = popcount(r_stable);
    end else begin
      w_level = {LW{1'b0}};
    end
    w_fault = !w_valid;
    w_empty = w_valid && (w_level == {LW{1'b0}});
    w_full  = w_valid && (w_level == LW'(NSENS));
    // Level k shows digit k-1; level 0 is handled as blank below.
    w_digit = 4'(w_level) - 4'd1;
  end

  // Blink generator: free-running only during a fault, restarting with the
  // 'E' visible at the start of every fault episode.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= {BW{1'b0}};
      r_phase     <= 1'b1;
    end else if (!w_fault) begin
      r_blink_cnt <= {BW{1'b0}};
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == BLINK_MAX) begin
      r_blink_cnt <= {BW{1'b0}};
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  // Segment pattern selection.
  always_comb begin
    w_seg = 8'h00;
    if (w_fault) begin
      if (r_phase) begin
        w_seg = 8'h79;
      end else begin
        w_seg = 8'h00;
      end
    end else if (w_level == {LW{1'b0}}) begin
      w_seg = 8'h00;
    end else begin
      w_seg = {w_full, seg_digit(w_digit)};
    end
  end

  assign SEG   = w_seg;
  assign level = w_level;
  assign valid = w_valid;
  assign fault = w_fault;
  assign empty = w_empty;
  assign full  = w_full;

endmodule

// File: tb/tb_level_display.sv
// Directed self-checking bench for level_display: a 3-sensor instance for
// the main behaviour and a 10-sensor instance for the widest configuration.
module tb_level_display;

  logic       clk_2;
  logic       rst_n;
  logic [2:0] sensor3;
  logic [9:0] sensor10;

  logic [7:0] seg3;
  logic [1:0] level3;
  logic       valid3, fault3, empty3, full3;

  logic [7:0] seg10;
  logic [3:0] level10;
  logic       valid10, fault10, empty10, full10;

  int checks;
  int failures;

  level_display #(.NSENS(3), .DEB_CYCLES(4), .BLINK_HALF(2)) u_dut3 (
    .clk_2 (clk_2),
    .rst_n (rst_n),
    .sensor(sensor3),
    .SEG   (seg3),
    .level (level3),
    .valid (valid3),
    .fault (fault3),
    .empty (empty3),
    .full  (full3)
  );

  level_display #(.NSENS(10), .DEB_CYCLES(4), .BLINK_HALF(2)) u_dut10 (
    .clk_2 (clk_2),
    .rst_n (rst_n),
    .sensor(sensor10),
    .SEG   (seg10),
    .level (level10),
    .valid (valid10),
    .fault (fault10),
    .empty (empty10),
    .full  (full10)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_2);
      @(negedge clk_2);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    sensor3  = 3'b111;
    sensor10 = 10'h000;

    // 1. Reset asserted between edges acts without a clock edge.
    @(negedge clk_2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seg",   16'(seg3),   16'h00);
    chk("rst_empty", 16'(empty3), 16'h1);
    chk("rst_level", 16'(level3), 16'h0);
    chk("rst_fault", 16'(fault3), 16'h0);
    chk("rst_valid", 16'(valid3), 16'h1);
    chk("rst_full",  16'(full3),  16'h0);
    chk("rst_seg10", 16'(seg10),  16'h00);
    @(negedge clk_2);
    sensor3 = 3'b000;
    rst_n   = 1'b1;
    step(2);

    // 2. Fill sequence.
    sensor3 = 3'b001;
    step(4);
    chk("fill1_e4_seg",   16'(seg3),   16'h00);
    chk("fill1_e4_level", 16'(level3), 16'h0);
    step(1);
    chk("fill1_seg",   16'(seg3),   16'h3F);
    chk("fill1_level", 16'(level3), 16'h1);
    chk("fill1_empty", 16'(empty3), 16'h0);
    sensor3 = 3'b011;
    step(4);
    chk("fill2_e4_seg", 16'(seg3), 16'h3F);
    step(1);
    chk("fill2_seg",   16'(seg3),   16'h06);
    chk("fill2_level", 16'(level3), 16'h2);
    sensor3 = 3'b111;
    step(5);
    chk("fill3_seg",   16'(seg3),   16'hDB);
    chk("fill3_level", 16'(level3), 16'h3);
    chk("fill3_full",  16'(full3),  16'h1);

    // 3. Glitch rejection: a 4-cycle pulse never commits.
    sensor3 = 3'b000;
    step(5);
    chk("glitch_base", 16'(seg3), 16'h00);
    sensor3 = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("glitch_pulse_seg",   16'(seg3),   16'h00);
      chk("glitch_pulse_empty", 16'(empty3), 16'h1);
    end
    sensor3 = 3'b000;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("glitch_after_seg",   16'(seg3),   16'h00);
      chk("glitch_after_empty", 16'(empty3), 16'h1);
    end

    // 4. Fault blink.
    sensor3 = 3'b101;
    step(4);
    chk("fault_e4", 16'(fault3), 16'h0);
    step(1);
    chk("fault_on",    16'(fault3), 16'h1);
    chk("fault_valid", 16'(valid3), 16'h0);
    chk("fault_level", 16'(level3), 16'h0);
    chk("blink0", 16'(seg3), 16'h79);
    step(1); chk("blink1", 16'(seg3), 16'h79);
    step(1); chk("blink2", 16'(seg3), 16'h00);
    step(1); chk("blink3", 16'(seg3), 16'h00);
    step(1); chk("blink4", 16'(seg3), 16'h79);
    step(1); chk("blink5", 16'(seg3), 16'h79);
    sensor3 = 3'b011;
    step(4);
    chk("recover_e4", 16'(fault3), 16'h1);
    step(1);
    chk("recover_fault", 16'(fault3), 16'h0);
    chk("recover_seg",   16'(seg3),   16'h06);

    // 5a. Reset mid-debounce discards the partial count.
    sensor3 = 3'b000;
    step(5);
    chk("mid_deb_base", 16'(seg3), 16'h00);
    sensor3 = 3'b011;
    step(2);
    rst_n = 1'b0;
    #1;
    chk("mid_deb_rst_seg", 16'(seg3), 16'h00);
    @(negedge clk_2);
    rst_n = 1'b1;
    step(4);
    chk("mid_deb_e4", 16'(seg3), 16'h00);
    step(1);
    chk("mid_deb_e5", 16'(seg3), 16'h06);

    // 5b. Reset mid-blink clears the fault immediately.
    sensor3 = 3'b101;
    step(7);
    chk("mid_blink_fault", 16'(fault3), 16'h1);
    chk("mid_blink_seg",   16'(seg3),   16'h00);
    sensor3 = 3'b000;
    rst_n   = 1'b0;
    #1;
    chk("mid_blink_rst_seg",   16'(seg3),   16'h00);
    chk("mid_blink_rst_fault", 16'(fault3), 16'h0);
    chk("mid_blink_rst_empty", 16'(empty3), 16'h1);
    @(negedge clk_2);
    rst_n = 1'b1;
    step(1);
    chk("mid_blink_after_fault", 16'(fault3), 16'h0);

    // 6. Ten-sensor boundary.
    sensor10 = 10'h3FF;
    step(4);
    chk("n10_e4_seg", 16'(seg10), 16'h00);
    step(1);
    chk("n10_level", 16'(level10), 16'hA);
    chk("n10_seg",   16'(seg10),   16'hEF);
    chk("n10_full",  16'(full10),  16'h1);
    sensor10 = 10'h3FE;
    step(5);
    chk("n10_fault",       16'(fault10), 16'h1);
    chk("n10_fault_seg",   16'(seg10),   16'h79);
    chk("n10_fault_level", 16'(level10), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/level_display.md
# level_display

Debounced, parametrised liquid-level indicator for the board top level. It samples an NSENS-bit thermometer-coded level sensor from the switches and filters it with a stable-count debouncer. It validates the code, then drives the 7-segment display and status flags. An invalid code (sensor fault) is reported as a blinking 'E'. Sits between SWI and SEG/LED in top; generalises the fixed 2-bit level decoder to N sensors with debounce, validation and alarm.

## Interface
- NSENS, 3: number of level sensors, legal range 1..10
- DEB_CYCLES, 4: consecutive equal samples required to accept a new sensor value, >= 1
- BLINK_HALF, 2: cycles per half-period of the fault blink, >= 1

- clk_2  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sensor  in  NSENS  bit i = 1 when liquid reaches sensor i; bit 0 is lowest
- SEG  out  8  bit 7 = decimal point, bits 6:0 = gfedcba, active-high
- level  out  $clog2(NSENS+1)  accepted level 0..NSENS
- valid  out  1  accepted code is a legal thermometer code
- fault  out  1  = !valid
- empty  out  1  valid && level == 0
- full  out  1  valid && level == NSENS

## Operation
- Registers: cand (NSENS), cnt (counter 0..DEB_CYCLES-1), stable (NSENS), blink_cnt (0..BLINK_HALF-1), phase (1 bit, 1 = on).
- Debounce, each edge:
  - sensor != cand: cand <= sensor, cnt <= 0.
  - sensor == cand and cnt == DEB_CYCLES-1: stable <= cand; cnt holds.
  - otherwise: cnt <= cnt+1.
- Validation is combinational on stable. Legal codes are stable == 2^k - 1 for k in 0..NSENS; then valid=1 and level=k. Any other code gives valid=0 and level=0.
- SEG when valid:
  - level 0: 0x00 (blank).
  - level k >= 1: digit k-1.
  - Digit table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - SEG[7] = full.
- SEG when fault: 0x79 ('E') while phase=1, 0x00 while phase=0.
- Blink:
  - fault=0: blink_cnt <= 0, phase <= 1.
  - fault=1: blink_cnt increments each edge. On wrap from BLINK_HALF-1 to 0, phase toggles.
  - Every fault episode therefore starts with 'E' shown for BLINK_HALF cycles, then blank for BLINK_HALF, repeating.
- Reset state: cand=0, cnt=0, stable=0, blink_cnt=0, phase=1.
- Resulting outputs in reset: SEG=0x00, level=0, valid=1, fault=0, empty=1, full=0.

## Timing
- An input change held steady is reflected on level/valid/flags/SEG after exactly DEB_CYCLES+1 rising edges. The first edge loads cand; stable updates on edge DEB_CYCLES+1.
- An input that changes again before commit restarts the count. Pulses shorter than DEB_CYCLES+1 cycles never reach stable.
- A pulse that returns to the already-stable value causes no output change.
- Outputs are combinational from stable/phase registers; no additional output register stage.
- Reset assertion clears all state immediately, independent of clk_2, including mid-debounce and mid-blink; partial counts are discarded.
- After rst_n deasserts, the first rising edge performs normal debounce sampling.
- Simultaneous commit of a valid code while blinking: the next cycle shows the valid display; phase/blink_cnt are reinitialised because fault=0.
- NSENS=1: codes 0 and 1 only. All codes are legal and fault is never asserted.

## Test plan
Bench parameters: NSENS=3, DEB_CYCLES=4, BLINK_HALF=2.
1. Reset: drive rst_n low between edges with sensor=3'b111 -> SEG=0x00, empty=1, level=0, fault=0 immediately, no clock edge needed.
2. Fill sequence: sensor 001 held.
   - After the 5th edge: level=1, SEG=0x3F; no change after the 4th edge.
   - Then 011: SEG=0x06, level=2.
   - Then 111: level=3, full=1, SEG=0xDB.
3. Glitch rejection: stable 000, sensor=001 for 4 cycles then back to 000 -> SEG stays 0x00, empty stays 1 throughout.
4. Fault blink:
   - sensor=101 held -> after 5th edge fault=1, valid=0, level=0.
   - SEG sequence per cycle: 79,79,00,00,79,79.
   - Then sensor=011 -> 5 edges later fault=0, SEG=0x06.
5. Reset mid-operation:
   - Mid-debounce: sensor=011 after 2 edges, assert rst_n=0 then release -> counting restarts; SEG=0x06 appears only 5 edges after release.
   - Mid-blink: reset during fault with sensor=000 -> SEG=0x00, fault=0 immediately.
6. Boundary: NSENS=10 instance, sensor=all ones -> level=10, SEG=0xEF (digit 9 plus decimal point); sensor=10'h3FE -> fault.
